score_bcd_scanner: RTL and testbench

//  Upstream feeder for the 7-segment display driver. Holds the game score as
//  4-digit packed BCD (0000-9999) and adds to it through a valid/ready

---
 rtl/score_bcd_scanner.sv | 136 +++++++++++++
 tb/tb_score_bcd_scanner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_scanner.sv
// Packed-BCD score keeper with valid/ready digit-serial adder, high-score tracking
// and the digit-scan index that multiplexes the 7-segment display.
module score_bcd_scanner #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        add_valid,
   input  logic [3:0]  add_val,
   output logic        add_ready,
   input  logic        clr,
   input  logic        disp_sel,
   output logic [15:0] score,
   output logic [15:0] hi_score,
   output logic [15:0] disp_value,
   output logic [1:0]  scanning,
   output logic        overflow
);

   localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned SW = 16;

   typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   score_q, score_d;
   logic [SW-1:0]   hi_q, hi_d;
   logic [SW-1:0]   work_q, work_d;
   logic [3:0]      op_q, op_d;
   logic [1:0]      idx_q, idx_d;
   logic            carry_q, carry_d;
   logic            ovf_q, ovf_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [1:0]      scan_q, scan_d;

   logic [3:0]      cur_digit;
   logic [4:0]      digit_sum;
   logic [SW-1:0]   new_score;

   // Free-running scan prescaler; never touched by clr or the adder
   always_comb begin
      presc_d = presc_q + PW'(1);
      scan_d  = scan_q;
      if (presc_q == PW'(SCAN_DIV - 1)) begin
         presc_d = '0;
         scan_d  = scan_q + 2'd1;
      end
   end

   // Adder FSM: one BCD digit per cycle, score only changes in COMMIT or on clr
   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      hi_d      = hi_q;
      work_d    = work_q;
      op_d      = op_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      cur_digit = work_q[{idx_q, 2'b00} +: 4];
      digit_sum = 5'(cur_digit) + 5'((idx_q == 2'd0) ? op_q : 4'd0) + 5'(carry_q);
      new_score = carry_q ? 16'h9999 : work_q;

      unique case (state_q)
         IDLE: begin
            if (add_valid) begin
               work_d  = score_q;
               op_d    = (add_val > 4'd9) ? 4'd9 : add_val;
               idx_d   = 2'd0;
               carry_d = 1'b0;
               state_d = ADD;
            end
         end
         ADD: begin
            if (digit_sum > 5'd9) begin
               work_d[{idx_q, 2'b00} +: 4] = 4'(digit_sum - 5'd10);
               carry_d                     = 1'b1;
            end else begin
               work_d[{idx_q, 2'b00} +: 4] = digit_sum[3:0];
               carry_d                     = 1'b0;
            end
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = COMMIT;
         end
         COMMIT: begin
            score_d = new_score;
            if (carry_q) ovf_d = 1'b1;
            if (new_score > hi_q) hi_d = new_score;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // clr discards any in-flight add, including one about to commit
      if (clr) begin
         score_d = '0;
         ovf_d   = 1'b0;
         hi_d    = hi_q;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         score_q <= '0;
         hi_q    <= '0;
         work_q  <= '0;
         op_q    <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         presc_q <= '0;
         scan_q  <= '0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         hi_q    <= hi_d;
         work_q  <= work_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         presc_q <= presc_d;
         scan_q  <= scan_d;
      end
   end

   assign add_ready  = (state_q == IDLE) && !clr;
   assign score      = score_q;
   assign hi_score   = hi_q;
   assign overflow   = ovf_q;
   assign scanning   = scan_q;
   assign disp_value = disp_sel ? hi_q : score_q;

endmodule

// File: tb/tb_score_bcd_scanner.sv
// Self-checking bench for score_bcd_scanner: decimal reference model feeding a
// scoreboard queue, a vector table for the basic adds, and hand-written corner cases.
module tb_score_bcd_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        add_valid;
   logic [3:0]  add_val;
   logic        add_ready;
   logic        clr;
   logic        disp_sel;
   logic [15:0] score, hi_score, disp_value;
   logic [1:0]  scanning;
   logic        overflow;

   score_bcd_scanner #(.SCAN_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .add_valid(add_valid), .add_val(add_val),
      .add_ready(add_ready), .clr(clr), .disp_sel(disp_sel), .score(score),
      .hi_score(hi_score), .disp_value(disp_value), .scanning(scanning),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] score;
      logic [15:0] hi;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [3:0]  v;
      logic [15:0] exp_score;
   } vec_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   score_m = 0, hi_m = 0;
   logic ovf_m = 1'b0;

   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] r;
      r[15:12] = 4'(n / 1000);
      r[11:8]  = 4'((n / 100) % 10);
      r[7:4]   = 4'((n / 10) % 10);
      r[3:0]   = 4'(n % 10);
      return r;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      score_m = 0;
      ovf_m   = 1'b0;
   endtask

   // One full add: drive, push the model's result, then pop and compare at commit
   task automatic do_add(input logic [3:0] v);
      int          vv, lowc;
      logic [15:0] pre;
      exp_t        e, got;
      vv = (v > 4'd9) ? 9 : int'(v);
      if (score_m + vv > 9999) begin
         score_m = 9999;
         ovf_m   = 1'b1;
      end else begin
         score_m = score_m + vv;
      end
      if (score_m > hi_m) hi_m = score_m;
      e.score = to_bcd(score_m);
      e.hi    = to_bcd(hi_m);
      e.ovf   = ovf_m;
      exp_q.push_back(e);

      pre       = score;
      add_valid = 1'b1;
      add_val   = v;
      tick();
      add_valid = 1'b0;
      add_val   = 4'($urandom);
      lowc      = 0;
      while (add_ready !== 1'b1 && lowc < 20) begin
         lowc++;
         chk("score_held_during_add", score, pre);
         tick();
      end
      chk("ready_low_cycles", 16'(lowc), 16'd5);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 16'd1, 16'd0);
      end else begin
         got = exp_q.pop_front();
         chk("commit_score", score, got.score);
         chk("commit_hi", hi_score, got.hi);
         chk("commit_ovf", 16'(overflow), 16'(got.ovf));
      end
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      model_clear();
   endtask

   initial begin
      vec_t tab[5];
      int   budget;
      logic [1:0] s0;

      tab[0] = '{4'd7, 16'h0007};
      tab[1] = '{4'd5, 16'h0012};
      tab[2] = '{4'hF, 16'h0021};
      tab[3] = '{4'd9, 16'h0030};
      tab[4] = '{4'd0, 16'h0030};

      rst_n = 1'b0; add_valid = 1'b0; add_val = 4'd0; clr = 1'b0; disp_sel = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("reset_score", score, 16'h0000);
      chk("reset_hi", hi_score, 16'h0000);
      chk("reset_ovf", 16'(overflow), 16'd0);
      chk("reset_ready", 16'(add_ready), 16'd1);

      // Basic adds including clamp of 4'hF to 9
      for (int i = 0; i < 5; i++) begin
         do_add(tab[i].v);
         chk("table_score", score, tab[i].exp_score);
      end
      chk("table_hi", hi_score, 16'h0030);

      // Abort: reach 0x0010, accept add of 3, clr two cycles after accept
      pulse_clr();
      do_add(4'd9);
      do_add(4'd1);
      chk("abort_pre", score, 16'h0010);
      add_valid = 1'b1; add_val = 4'd3;
      tick();
      add_valid = 1'b0;
      tick();
      clr = 1'b1;
      tick();
      chk("abort_score_cleared", score, 16'h0000);
      clr = 1'b0;
      #1;
      chk("abort_ready", 16'(add_ready), 16'd1);
      model_clear();
      repeat (6) tick();
      chk("abort_no_commit", score, 16'h0000);

      // clr and add_valid together: no accept
      clr = 1'b1; add_valid = 1'b1; add_val = 4'd4;
      #1;
      chk("clr_blocks_ready", 16'(add_ready), 16'd0);
      tick();
      clr = 1'b0; add_valid = 1'b0;
      repeat (6) tick();
      chk("clr_wins_score", score, 16'h0000);
      chk("clr_wins_ready", 16'(add_ready), 16'd1);

      // Async reset mid-count with scanning nonzero
      budget = 0;
      while (scanning == 2'd0 && budget < 20) begin budget++; tick(); end
      chk("scan_nonzero_before_rst", 16'(scanning == 2'd0), 16'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_scan", 16'(scanning), 16'd0);
      chk("async_rst_hi", hi_score, 16'h0000);
      tick();
      rst_n = 1'b1;
      model_clear();
      hi_m = 0;
      tick();

      // hi_score hold and display mux
      for (int i = 0; i < 5; i++) do_add(4'd9);
      do_add(4'd5);
      chk("hold_pre", score, 16'h0050);
      pulse_clr();
      do_add(4'd9); do_add(4'd9); do_add(4'd2);
      chk("hold_hi", hi_score, 16'h0050);
      disp_sel = 1'b1;
      #1;
      chk("disp_hi", disp_value, 16'h0050);
      disp_sel = 1'b0;
      #1;
      chk("disp_score", disp_value, 16'h0020);

      // Ripple carry 0999 + 1
      pulse_clr();
      for (int i = 0; i < 111; i++) do_add(4'd9);
      chk("ripple_pre", score, 16'h0999);
      do_add(4'd1);
      chk("ripple_score", score, 16'h1000);
      chk("ripple_ovf", 16'(overflow), 16'd0);

      // Saturation from 9995
      pulse_clr();
      for (int i = 0; i < 1110; i++) do_add(4'd9);
      do_add(4'd5);
      chk("sat_pre", score, 16'h9995);
      do_add(4'd9);
      chk("sat_score", score, 16'h9999);
      chk("sat_ovf", 16'(overflow), 16'd1);
      do_add(4'd0);
      chk("sat_add0_score", score, 16'h9999);
      chk("sat_add0_ovf", 16'(overflow), 16'd1);
      pulse_clr();
      chk("sat_clr_score", score, 16'h0000);
      chk("sat_clr_ovf", 16'(overflow), 16'd0);
      chk("sat_clr_hi", hi_score, 16'h9999);

      // Scanner steps every 4 clocks regardless of clr/adds
      budget = 0;
      s0 = scanning;
      while (scanning == s0 && budget < 20) begin budget++; tick(); end
      chk("scan_align", 16'(budget < 20), 16'd1);
      s0 = scanning;
      for (int k = 1; k <= 5; k++) begin
         add_valid = (k % 2) == 1;
         add_val   = 4'd1;
         clr       = (k == 3);
         repeat (3) tick();
         chk("scan_hold", 16'(scanning), 16'(2'(s0 + 2'(k - 1))));
         tick();
         chk("scan_step", 16'(scanning), 16'(2'(s0 + 2'(k))));
      end
      add_valid = 1'b0;
      clr = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
